// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with load/start/pause control and a TICK_DIV-cycle prescaler.
// Optional macro AUTO_RELOAD_EN: on expiry, reload the count from the preset and keep running.
module bcd_down_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] cnt_ones,
    output logic [3:0] cnt_tens,
    output logic       zero,
    output logic       done,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic [15:0] presc_q, presc_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

`ifdef AUTO_RELOAD_EN
    // The preset is only ever read back by the auto-reload path.
    logic [7:0]  preset_q, preset_d;
`endif

    logic load_ok;
    logic tick;
    logic at_one;

    assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    assign tick    = (presc_q == PRESC_MAX);
    assign at_one  = (tens_q == 4'd0) && (ones_q == 4'd1);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef AUTO_RELOAD_EN
        preset_d = preset_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // load outranks start; an invalid load still swallows start
                if (load) begin
                    if (load_ok) begin
                        ones_d   = load_val[3:0];
                        tens_d   = load_val[7:4];
`ifdef AUTO_RELOAD_EN
                        preset_d = load_val;
`endif
                        state_d  = S_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (start && !zero) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end

            S_RUN: begin
                if (pause) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    presc_d = '0;
                    if (at_one) begin
                        done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                        ones_d = preset_q[3:0];
                        tens_d = preset_q[7:4];
`else
                        ones_d  = 4'd0;
                        tens_d  = 4'd0;
                        state_d = S_DONE;
`endif
                    end else if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end

            S_PAUSE: begin
                if (start && !pause) begin
                    state_d = S_RUN;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            presc_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef AUTO_RELOAD_EN
            preset_q <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef AUTO_RELOAD_EN
            preset_q <= preset_d;
`endif
        end
    end

    assign cnt_ones = ones_q;
    assign cnt_tens = tens_q;
    assign zero     = (ones_q == 4'd0) && (tens_q == 4'd0);
    assign done     = done_q;
    assign busy     = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign err      = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: two instances (TICK_DIV=1 and 4) share stimulus and are
// compared each cycle against a decimal-arithmetic reference model.
module tb_bcd_down_timer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;

    logic [3:0] ones1, tens1, ones4, tens4;
    logic       zero1, done1, busy1, err1;
    logic       zero4, done4, busy4, err4;

    int checks = 0;
    int errors = 0;

    bcd_down_timer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .start(start), .pause(pause),
        .cnt_ones(ones1), .cnt_tens(tens1), .zero(zero1), .done(done1), .busy(busy1), .err(err1)
    );

    bcd_down_timer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .start(start), .pause(pause),
        .cnt_ones(ones4), .cnt_tens(tens4), .zero(zero4), .done(done4), .busy(busy4), .err(err4)
    );

    always #5 clk = ~clk;

    // Reference model: count kept as a plain integer 0..99, index 0 = TICK_DIV 1, index 1 = TICK_DIV 4
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    int m_state[2];
    int m_val[2];
    int m_preset[2];
    int m_presc[2];
    bit m_done[2];
    bit m_err[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = M_IDLE; m_val[k] = 0; m_preset[k] = 0; m_presc[k] = 0;
            m_done[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit ld, input logic [7:0] lv, input bit st, input bit ps);
        int tdv;
        for (int k = 0; k < 2; k++) begin
            tdv = (k == 0) ? 1 : 4;
            m_done[k] = 1'b0;
            m_err[k]  = 1'b0;
            case (m_state[k])
                M_IDLE, M_DONE: begin
                    if (ld) begin
                        if (int'(lv[7:4]) > 9 || int'(lv[3:0]) > 9) m_err[k] = 1'b1;
                        else begin
                            m_val[k]    = int'(lv[7:4]) * 10 + int'(lv[3:0]);
                            m_preset[k] = m_val[k];
                            m_state[k]  = M_IDLE;
                        end
                    end else if (st && m_val[k] != 0) begin
                        m_state[k] = M_RUN;
                        m_presc[k] = 0;
                    end
                end
                M_RUN: begin
                    if (ps) m_state[k] = M_PAUSE;
                    else begin
                        m_presc[k]++;
                        if (m_presc[k] == tdv) begin
                            m_presc[k] = 0;
                            m_val[k]--;
                            if (m_val[k] == 0) begin
                                m_done[k] = 1'b1;
`ifdef AUTO_RELOAD_EN
                                m_val[k] = m_preset[k];
`else
                                m_state[k] = M_DONE;
`endif
                            end
                        end
                    end
                end
                M_PAUSE: if (st && !ps) m_state[k] = M_RUN;
                default: ;
            endcase
        end
    endtask

    function automatic logic [11:0] obs_vec(input int k);
        if (k == 0) return {tens1, ones1, zero1, done1, busy1, err1};
        return {tens4, ones4, zero4, done4, busy4, err4};
    endfunction

    function automatic logic [11:0] exp_vec(input int k);
        logic [3:0] t, o;
        t = 4'(m_val[k] / 10);
        o = 4'(m_val[k] % 10);
        return {t, o, m_val[k] == 0, m_done[k], m_state[k] == M_RUN || m_state[k] == M_PAUSE, m_err[k]};
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
    task automatic step(input bit ld, input logic [7:0] lv, input bit st, input bit ps);
        load = ld; load_val = lv; start = st; pause = ps;
        model_step(ld, lv, st, ps);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        load = 1'b0; start = 1'b0; pause = 1'b0;
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== 12'h008) begin
                errors++;
                $display("FAIL reset_state dut%0d got %h expected %h", k, obs_vec(k), 12'h008);
            end
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== 12'h008) begin
                errors++;
                $display("FAIL start_at_zero dut%0d got %h expected %h", k, obs_vec(k), 12'h008);
            end
        end
    endtask

`ifndef AUTO_RELOAD_EN
    task automatic test_count_sequence();
        int done_cnt;
        done_cnt = 0;
        do_reset();
        step(1'b1, 8'h12, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 11; i >= 0; i--) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (done1) done_cnt++;
            checks++;
            if ({tens1, ones1} !== bcd(i)) begin
                errors++;
                $display("FAIL seq_count got %h expected %h", {tens1, ones1}, bcd(i));
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL seq_model dut%0d got %h expected %h", k, obs_vec(k), exp_vec(k));
                end
            end
        end
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL seq_expire done=%b busy=%b expected done=1 busy=0", done1, busy1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (done_cnt !== 1 || done1 !== 1'b0 || busy1 !== 1'b0 || zero1 !== 1'b1) begin
            errors++;
            $display("FAIL seq_after pulses=%0d done=%b busy=%b zero=%b expected 1 0 0 1",
                     done_cnt, done1, busy1, zero1);
        end
    endtask
`endif

    task automatic test_bad_load();
        do_reset();
        step(1'b1, 8'h3A, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== 12'h009) begin
                errors++;
                $display("FAIL bad_load_err dut%0d got %h expected %h", k, obs_vec(k), 12'h009);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== 12'h008) begin
                errors++;
                $display("FAIL bad_load_clear dut%0d got %h expected %h", k, obs_vec(k), 12'h008);
            end
        end
        step(1'b1, 8'h45, 1'b0, 1'b0);
        step(1'b1, 8'h4F, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== {8'h45, 4'b0001}) begin
                errors++;
                $display("FAIL bad_load_keep dut%0d got %h expected %h", k, obs_vec(k), {8'h45, 4'b0001});
            end
        end
        step(1'b1, 8'h27, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== {8'h27, 4'b0000}) begin
                errors++;
                $display("FAIL load_beats_start dut%0d got %h expected %h", k, obs_vec(k), {8'h27, 4'b0000});
            end
        end
    endtask

    // Cycles from the start edge until dut4 pulses done, optionally pausing for 10 cycles.
    task automatic run_and_measure(input bit with_pause, output int lat);
        lat = 0;
        do_reset();
        step(1'b1, 8'h05, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        while (!done4 && lat < 200) begin
            if (with_pause && lat == 6) begin
                for (int j = 0; j < 9; j++) begin
                    step(1'b0, 8'h00, 1'b0, 1'b1);
                    lat++;
                    checks++;
                    if ({tens4, ones4} !== 8'h04 || busy4 !== 1'b1) begin
                        errors++;
                        $display("FAIL pause_hold got %h busy=%b expected 04 busy=1", {tens4, ones4}, busy4);
                    end
                end
                step(1'b0, 8'h00, 1'b1, 1'b0);
            end else begin
                step(1'b0, 8'h00, 1'b0, 1'b0);
            end
            lat++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL pause_model dut%0d got %h expected %h", k, obs_vec(k), exp_vec(k));
                end
            end
        end
        checks++;
        if (!done4) begin
            errors++;
            $display("FAIL pause_timeout no done within %0d cycles", lat);
        end
    endtask

    task automatic test_pause();
        int lat_plain, lat_paused;
        run_and_measure(1'b0, lat_plain);
        run_and_measure(1'b1, lat_paused);
        checks++;
        if (lat_plain !== 5 * 4 || lat_paused - lat_plain !== 10) begin
            errors++;
            $display("FAIL pause_latency got %0d/%0d expected %0d/%0d",
                     lat_plain, lat_paused, 20, 30);
        end
    endtask

    task automatic test_start_pause_together();
        do_reset();
        step(1'b1, 8'h15, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        checks++;
        if ({tens1, ones1} !== 8'h12 || {tens4, ones4} !== 8'h15 || busy1 !== 1'b1 ||
            busy4 !== 1'b1 || err1 !== 1'b0 || err4 !== 1'b0) begin
            errors++;
            $display("FAIL pause_ignores_load got %h/%h busy=%b%b err=%b%b expected 12/15 busy=11 err=00",
                     {tens1, ones1}, {tens4, ones4}, busy1, busy4, err1, err4);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({tens4, ones4} !== 8'h14 || {tens1, ones1} !== 8'h11) begin
            errors++;
            $display("FAIL resume got %h/%h expected 11/14", {tens1, ones1}, {tens4, ones4});
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        step(1'b1, 8'h15, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (8) step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({tens1, ones1} !== 8'h07 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_count got %h busy=%b expected 07 busy=1", {tens1, ones1}, busy1);
        end
        rstn = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== 12'h008) begin
                errors++;
                $display("FAIL mid_run_reset dut%0d got %h expected %h", k, obs_vec(k), 12'h008);
            end
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== 12'h008) begin
                errors++;
                $display("FAIL post_reset_start dut%0d got %h expected %h", k, obs_vec(k), 12'h008);
            end
        end
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload();
        do_reset();
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if ({tens1, ones1} !== bcd(3 - (i % 3)) || done1 !== (i % 3 == 0) || busy1 !== 1'b1) begin
                errors++;
                $display("FAIL auto_reload i=%0d got %h done=%b busy=%b expected %h done=%b busy=1",
                         i, {tens1, ones1}, done1, busy1, bcd(3 - (i % 3)), i % 3 == 0);
            end
        end
    endtask
`endif

    task automatic test_random();
        bit ld, st, ps;
        logic [7:0] lv;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ld = ($urandom_range(0, 9) == 0);
            lv = ($urandom_range(0, 1) == 0) ? {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))}
                                              : 8'($urandom);
            st = ($urandom_range(0, 3) == 0);
            ps = ($urandom_range(0, 7) == 0);
            step(ld, lv, st, ps);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random n=%0d dut%0d got %h expected %h", n, k, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
`ifndef AUTO_RELOAD_EN
        test_count_sequence();
`else
        test_auto_reload();
`endif
        test_bad_load();
        test_pause();
        test_start_pause_together();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
